// File: rtl/map_tile_arbiter.sv
// Map tile arbiter: shares the single-port map BRAM between the video fetch
// path, which always has priority, and physics tile lookups, which are only
// served while video is idle (blanking).
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a physics request (phys_ready_out high)
// PEND  | request latched, waiting for a free BRAM cycle (or skipped if OOB)
// WAIT  | two-cycle BRAM read latency, tile captured on the second cycle
// RESP  | phys_rvalid_out strobe for one cycle
module map_tile_arbiter #(
    parameter int unsigned WIDTH    = 160,
    parameter int unsigned HEIGHT   = 90,
    parameter logic [3:0]  OOB_TILE = 4'h1,
    localparam int unsigned ADDR_W  = $clog2(WIDTH * HEIGHT)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              vid_active_in,
    input  logic [ADDR_W-1:0] vid_addr_in,
    input  logic              phys_valid_in,
    input  logic [7:0]        phys_x_in,
    input  logic [6:0]        phys_y_in,
    output logic              phys_ready_out,
    output logic              phys_rvalid_out,
    output logic [3:0]        phys_tile_out,
    output logic              phys_oob_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    input  logic [3:0]        bram_dout_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_oob_q, pend_oob_d;
    logic              wait_cnt_q, wait_cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [3:0]        tile_q, tile_d;
    logic              oob_q, oob_d;

    logic [ADDR_W-1:0] req_addr;
    logic              req_oob;
    logic              issue;

    // Linear tile address and range check of the incoming coordinates.
    assign req_addr = ADDR_W'(phys_x_in) + ADDR_W'(phys_y_in) * ADDR_W'(WIDTH);
    assign req_oob  = (32'(phys_x_in) >= WIDTH) || (32'(phys_y_in) >= HEIGHT);

    // Physics only drives the BRAM in a free cycle; video wins any collision.
    assign issue         = (state_q == PEND) && !pend_oob_q && !vid_active_in;
    assign bram_addr_out = issue ? pend_addr_q : vid_addr_in;

    assign phys_ready_out  = ready_q;
    assign phys_rvalid_out = rvalid_q;
    assign phys_tile_out   = tile_q;
    assign phys_oob_out    = oob_q;

    // Next-state logic and response capture.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_oob_d  = pend_oob_q;
        wait_cnt_d  = wait_cnt_q;
        tile_d      = tile_q;
        oob_d       = oob_q;
        case (state_q)
            IDLE: begin
                if (phys_valid_in && ready_q) begin
                    state_d     = PEND;
                    pend_addr_d = req_addr;
                    pend_oob_d  = req_oob;
                end
            end
            PEND: begin
                // Out-of-range requests never touch the BRAM.
                if (pend_oob_q || !vid_active_in) begin
                    state_d    = WAIT;
                    wait_cnt_d = 1'b0;
                end
            end
            WAIT: begin
                if (wait_cnt_q) begin
                    wait_cnt_d = 1'b0;
                    tile_d     = pend_oob_q ? OOB_TILE : bram_dout_in;
                    oob_d      = pend_oob_q;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered and follow the next state.
    always_comb begin
        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == RESP);
    end

    // State and datapath registers.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_oob_q  <= 1'b0;
            wait_cnt_q  <= 1'b0;
            ready_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            tile_q      <= 4'h0;
            oob_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_oob_q  <= pend_oob_d;
            wait_cnt_q  <= wait_cnt_d;
            ready_q     <= ready_d;
            rvalid_q    <= rvalid_d;
            tile_q      <= tile_d;
            oob_q       <= oob_d;
        end
    end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Bench for map_tile_arbiter: a 2-cycle-latency BRAM model plus a
// request-level reference model (expected address, tile and response cycle).
module tb_map_tile_arbiter;

    localparam int W = 160;
    localparam int H = 90;

    logic        clk;
    logic        rst;
    logic        vid_active;
    logic [13:0] vid_addr;
    logic        phys_valid;
    logic [7:0]  phys_x;
    logic [6:0]  phys_y;
    logic        phys_ready;
    logic        phys_rvalid;
    logic [3:0]  phys_tile;
    logic        phys_oob;
    logic [13:0] bram_addr;
    logic [3:0]  bram_dout;

    int total = 0;
    int bad   = 0;

    logic [3:0]  mem [0:16383];
    logic [13:0] bram_a1 = '0;

    map_tile_arbiter dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .vid_active_in  (vid_active),
        .vid_addr_in    (vid_addr),
        .phys_valid_in  (phys_valid),
        .phys_x_in      (phys_x),
        .phys_y_in      (phys_y),
        .phys_ready_out (phys_ready),
        .phys_rvalid_out(phys_rvalid),
        .phys_tile_out  (phys_tile),
        .phys_oob_out   (phys_oob),
        .bram_addr_out  (bram_addr),
        .bram_dout_in   (bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with two-cycle read latency.
    always @(posedge clk) begin
        bram_a1   <= bram_addr;
        bram_dout <= mem[bram_a1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; phys_valid = 1'b0; vid_active = 1'b0;
        phys_x = '0; phys_y = '0; vid_addr = 14'd77;
        #3;
        total++; if (phys_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", phys_ready); end
        total++; if (phys_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%0b want=0", phys_rvalid); end
        total++; if (phys_tile !== 4'h0) begin bad++; $display("FAIL rst_tile got=%0h want=0", phys_tile); end
        total++; if (phys_oob !== 1'b0) begin bad++; $display("FAIL rst_oob got=%0b want=0", phys_oob); end
        step(); step();
        vid_addr = 14'd1234; #1;
        total++; if (bram_addr !== 14'd1234) begin bad++; $display("FAIL rst_bram_addr got=%0d want=1234", bram_addr); end
        rst = 1'b1; #1;
        total++; if (phys_ready !== 1'b0) begin bad++; $display("FAIL rel_ready_early got=%0b want=0", phys_ready); end
        step();
        total++; if (phys_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%0b want=1", phys_ready); end
    endtask

    // One lookup: vid_active held high for vid_hold cycles after acceptance,
    // then random (rnd) or low. Checks address routing, latency and result.
    task automatic do_request(input int x, input int y, input int vid_hold, input bit rnd);
        bit          exp_oob;
        int          exp_addr;
        logic [3:0]  exp_tile;
        int          issue_k;
        bit          done;
        bit          exp_rv;
        logic [13:0] want_addr;
        int          k;
        exp_oob  = (x >= W) || (y >= H);
        exp_addr = (x + y * W) % 16384;
        exp_tile = exp_oob ? 4'h1 : mem[exp_addr];
        k = 0;
        phys_valid = 1'b0; #1;
        while (phys_ready !== 1'b1 && k < 20) begin step(); k++; #1; end
        total++; if (phys_ready !== 1'b1) begin bad++; $display("FAIL ready_wait got=%0b want=1", phys_ready); end
        vid_active = 1'($urandom_range(0, 1));
        vid_addr   = 14'($urandom_range(0, 14399));
        phys_valid = 1'b1; phys_x = 8'(x); phys_y = 7'(y);
        #1;
        total++; if (bram_addr !== vid_addr) begin bad++; $display("FAIL idle_addr got=%0d want=%0d", bram_addr, vid_addr); end
        step();
        issue_k = -1; done = 1'b0;
        for (k = 1; k < 300 && !done; k++) begin
            phys_valid = 1'($urandom_range(0, 1));
            phys_x     = 8'($urandom);
            phys_y     = 7'($urandom);
            vid_active = (k <= vid_hold) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
            vid_addr   = 14'($urandom_range(0, 14399));
            #1;
            want_addr = vid_addr;
            if (issue_k < 0 && (exp_oob || !vid_active)) begin
                issue_k = k;
                if (!exp_oob) want_addr = 14'(exp_addr);
            end
            total++; if (bram_addr !== want_addr) begin bad++; $display("FAIL bram_addr k=%0d got=%0d want=%0d", k, bram_addr, want_addr); end
            exp_rv = (issue_k >= 0) && (k == issue_k + 3);
            total++; if (phys_rvalid !== exp_rv) begin bad++; $display("FAIL rvalid k=%0d got=%0b want=%0b", k, phys_rvalid, exp_rv); end
            total++; if (phys_ready !== 1'b0) begin bad++; $display("FAIL busy_ready k=%0d got=%0b want=0", k, phys_ready); end
            if (exp_rv) begin
                done = 1'b1;
                total++; if (phys_tile !== exp_tile) begin bad++; $display("FAIL tile x=%0d y=%0d got=%0h want=%0h", x, y, phys_tile, exp_tile); end
                total++; if (phys_oob !== exp_oob) begin bad++; $display("FAIL oob x=%0d y=%0d got=%0b want=%0b", x, y, phys_oob, exp_oob); end
            end
            step();
        end
        total++; if (!done) begin bad++; $display("FAIL resp_timeout got=none want=response"); end
        phys_valid = 1'b0; #1;
        total++; if (phys_ready !== 1'b1) begin bad++; $display("FAIL post_ready got=%0b want=1", phys_ready); end
        total++; if (phys_rvalid !== 1'b0) begin bad++; $display("FAIL post_rvalid got=%0b want=0", phys_rvalid); end
        total++; if (phys_tile !== exp_tile) begin bad++; $display("FAIL hold_tile got=%0h want=%0h", phys_tile, exp_tile); end
    endtask

    task automatic test_basic();
        mem[323] = 4'h2;
        do_request(3, 2, 0, 1'b0);
    endtask

    task automatic test_contention();
        do_request(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 100, 1'b0);
    endtask

    task automatic test_oob();
        do_request(160, 0, 10, 1'b0);
    endtask

    task automatic test_corner();
        do_request(159, 89, 0, 1'b0);
        do_request(0, 90, 0, 1'b0);
        do_request(159, 89, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            do_request(int'($urandom_range(0, 175)), int'($urandom_range(0, 100)), 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int         xs [10];
        int         ys [10];
        logic [3:0] exp_q [$];
        int         due_q [$];
        int         idx;
        int         resp;
        int         last_acc;
        int         cyc;
        bit         exp_rv;
        logic [3:0] t;
        idx = 0; resp = 0; last_acc = -1; cyc = 0;
        for (int i = 0; i < 10; i++) begin xs[i] = i * 13 + 1; ys[i] = i * 7 + 2; end
        vid_active = 1'b0;
        while (resp < 10 && cyc < 200) begin
            phys_valid = (idx < 10);
            phys_x     = 8'(xs[(idx < 10) ? idx : 9]);
            phys_y     = 7'(ys[(idx < 10) ? idx : 9]);
            vid_addr   = 14'($urandom_range(0, 14399));
            #1;
            exp_rv = (due_q.size() > 0) && (due_q[0] == cyc);
            total++; if (phys_rvalid !== exp_rv) begin bad++; $display("FAIL b2b_rvalid cyc=%0d got=%0b want=%0b", cyc, phys_rvalid, exp_rv); end
            if (phys_rvalid === 1'b1 && exp_q.size() > 0) begin
                t = exp_q.pop_front();
                void'(due_q.pop_front());
                resp++;
                total++; if (phys_tile !== t) begin bad++; $display("FAIL b2b_tile n=%0d got=%0h want=%0h", resp, phys_tile, t); end
            end
            if (phys_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    total++; if (cyc - last_acc !== 5) begin bad++; $display("FAIL b2b_spacing got=%0d want=5", cyc - last_acc); end
                end
                last_acc = cyc;
                if (idx < 10) begin
                    exp_q.push_back(mem[xs[idx] + ys[idx] * W]);
                    due_q.push_back(cyc + 4);
                    idx++;
                end
            end
            step();
            cyc++;
        end
        phys_valid = 1'b0;
        total++; if (resp !== 10) begin bad++; $display("FAIL b2b_count got=%0d want=10", resp); end
    endtask

    task automatic test_reset_mid_wait();
        int k;
        k = 0;
        phys_valid = 1'b0; vid_active = 1'b0; #1;
        while (phys_ready !== 1'b1 && k < 20) begin step(); k++; #1; end
        mem[5 + 5 * W] = 4'h9;
        phys_valid = 1'b1; phys_x = 8'd5; phys_y = 7'd5;
        step();
        phys_valid = 1'b0;
        step();
        step();
        rst = 1'b0; vid_addr = 14'd999; #1;
        total++; if (phys_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%0b want=0", phys_ready); end
        total++; if (phys_tile !== 4'h0) begin bad++; $display("FAIL mid_tile got=%0h want=0", phys_tile); end
        total++; if (bram_addr !== 14'd999) begin bad++; $display("FAIL mid_addr got=%0d want=999", bram_addr); end
        step();
        rst = 1'b1;
        step();
        total++; if (phys_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%0b want=1", phys_ready); end
        for (int i = 0; i < 8; i++) begin
            total++; if (phys_rvalid !== 1'b0) begin bad++; $display("FAIL mid_ghost i=%0d got=%0b want=0", i, phys_rvalid); end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom);
        test_reset();
        test_basic();
        test_contention();
        test_oob();
        test_corner();
        test_random();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_tile_arbiter.md
MAP_TILE_ARBITER -- requirements
Module: map_tile_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 160, giving the map width in tiles.
REQ-002 SHALL have parameter HEIGHT, default 90, giving the map height in tiles.
REQ-003 SHALL have parameter OOB_TILE, default 4'h1 (wall), returned for out-of-range lookups.
REQ-004 SHALL derive ADDR_W = $clog2(WIDTH*HEIGHT), which is 14 at the defaults.
REQ-005 pixel_clk_in  in  1  sole clock; every register is rising-edge.
REQ-006 rst_in  in  1  reset, asynchronous, active-low.
REQ-007 vid_active_in  in  1  video fetch owns the map BRAM this cycle.
REQ-008 vid_addr_in  in  ADDR_W  video tile address.
REQ-009 phys_valid_in  in  1  physics lookup request.
REQ-010 phys_x_in  in  8  tile column.
REQ-011 phys_y_in  in  7  tile row.
REQ-012 phys_ready_out  out  1  arbiter accepts a request.
REQ-013 phys_rvalid_out  out  1  one-cycle response strobe.
REQ-014 phys_tile_out  out  4  tile code returned to physics.
REQ-015 phys_oob_out  out  1  response came from an out-of-range request.
REQ-016 bram_addr_out  out  ADDR_W  address to the single-port map BRAM (2-cycle read latency).
REQ-017 bram_dout_in  in  4  map BRAM read data.

Function
REQ-018 SHALL share the one map BRAM port between video (absolute priority) and physics (blanking-only access).
REQ-019 bram_addr_out SHALL be combinational: pend_addr when state==PEND, in-range and vid_active_in==0; vid_addr_in otherwise.
REQ-020 SHALL implement a four-state FSM: IDLE, PEND, WAIT, RESP.
REQ-021 Handshake: a request is accepted only on a cycle where phys_valid_in & phys_ready_out are both high.
REQ-022 phys_ready_out SHALL be registered and high only while in IDLE; it drops in the cycle after acceptance.
REQ-023 phys_x_in and phys_y_in are sampled only at acceptance; later changes SHALL have no effect.
REQ-024 IDLE->PEND on acceptance, registering pend_addr = x + y*WIDTH (ADDR_W bits, unsigned) and oob = (x>=WIDTH)|(y>=HEIGHT).
REQ-025 PEND, in-range, vid_active_in==0: SHALL issue pend_addr this cycle and go to WAIT.
REQ-026 PEND, in-range, vid_active_in==1: SHALL hold PEND indefinitely with no timeout; a rise of vid_active_in in the same cycle as the issue attempt means video wins.
REQ-027 PEND, oob==1: SHALL go to WAIT without driving the BRAM, regardless of vid_active_in.
REQ-028 WAIT SHALL count 2 cycles using a 1-bit counter.
REQ-029 On the final WAIT cycle: SHALL register phys_tile_out = oob ? OOB_TILE : bram_dout_in, register phys_oob_out = oob, and go to RESP.
REQ-030 RESP: phys_rvalid_out SHALL be high for exactly 1 cycle, then the FSM returns to IDLE.
REQ-031 phys_ready_out SHALL be high again the cycle after RESP.
REQ-032 Minimum latency SHALL be: acceptance at cycle T, issue at T+1, phys_rvalid_out at T+4.
REQ-033 phys_tile_out and phys_oob_out SHALL hold their values until the next response.
REQ-034 Boundary x=WIDTH-1, y=HEIGHT-1 is in range and gives address 14399 at the defaults.
REQ-035 Boundary x=WIDTH or y=HEIGHT is out of range.
REQ-036 phys_valid_in asserted while phys_ready_out is low SHALL be ignored; no queuing.

Reset
REQ-037 rst_in low SHALL asynchronously force: state IDLE, phys_ready_out 0, phys_rvalid_out 0, phys_tile_out 0, phys_oob_out 0, pend_addr 0, WAIT counter 0.
REQ-038 phys_ready_out SHALL rise on the first clock edge after rst_in is released.
REQ-039 Reset mid-transaction (PEND, WAIT or RESP) SHALL drop the request: no phys_rvalid_out pulse for it afterwards.
REQ-040 During reset, bram_addr_out SHALL follow vid_addr_in.

Verification
REQ-041 Idle-blanking lookup: vid_active_in=0; request x=3,y=2 (addr 323, BRAM returns 4'h2) -> bram_addr_out=323 at T+1, phys_rvalid_out at T+4, phys_tile_out=2, phys_oob_out=0.
REQ-042 Video contention: vid_active_in=1 for 100 cycles after acceptance -> bram_addr_out==vid_addr_in throughout, issue on first cycle vid_active_in=0, phys_rvalid_out exactly 3 cycles later.
REQ-043 Out-of-range: x=160,y=0 with vid_active_in=1 -> no BRAM drive, phys_rvalid_out at T+4, phys_tile_out=1, phys_oob_out=1.
REQ-044 Corner: x=159,y=89 -> bram_addr_out=14399; x=0,y=90 -> phys_oob_out=1.
REQ-045 Back-to-back: phys_valid_in held high with 10 distinct coords -> one acceptance per 5 cycles, responses in order, each ready=1 only in IDLE.
REQ-046 Reset mid-WAIT: rst_in low 1 cycle -> all outputs 0 immediately, no rvalid pulse for the dropped request, phys_ready_out=1 on the edge after release.
